// File: rtl/sram_req_arbiter_pkg.sv
// ---------------------------------------------------------------------------
// sram_ArbPkg
// Shared definitions for the two-port SRAM request arbiter:
//   - request/response type encodings (read / write)
//   - port identifier type (one bit: port 0 or port 1)
//   - response queue depth, which is also the per-port credit limit
// ---------------------------------------------------------------------------
package sram_ArbPkg;

    // Request / response type encodings
    localparam logic REQ_READ  = 1'b0;
    localparam logic REQ_WRITE = 1'b1;

    // Port identifier
    typedef logic port_id_t;
    localparam port_id_t PORT0 = 1'b0;
    localparam port_id_t PORT1 = 1'b1;

    // Entries per response queue; also the most requests a port may have
    // outstanding (queued + in flight) at once.
    localparam logic [1:0] RESP_Q_DEPTH = 2'd2;

endpackage

// File: rtl/sram_req_arbiter_resp_queue.sv
// ---------------------------------------------------------------------------
// sram_RespQueue
// Two-entry response FIFO holding {type, data}, with bypass when empty: an
// incoming response is presented combinationally on the dequeue side in the
// same cycle and is only stored if it is not consumed.
// The producer never enqueues into a full queue (the arbiter's credit check
// guarantees it), so there is no enqueue-ready output.
// Ports:
//   clk, reset            clock, asynchronous active-high reset
//   enq_val/type/data     incoming response
//   deq_val/rdy/type/data outgoing response handshake
//   count                 number of stored entries (0..2)
// ---------------------------------------------------------------------------
module sram_RespQueue
    import sram_ArbPkg::*;
#(
    parameter int p_data_nbits = 32
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    enq_val,
    input  logic                    enq_type,
    input  logic [p_data_nbits-1:0] enq_data,
    output logic                    deq_val,
    input  logic                    deq_rdy,
    output logic                    deq_type,
    output logic [p_data_nbits-1:0] deq_data,
    output logic [1:0]              count
);

    logic                    head_type_r;
    logic [p_data_nbits-1:0] head_data_r;
    logic                    tail_type_r;
    logic [p_data_nbits-1:0] tail_data_r;
    logic [1:0]              count_r;

    logic                    empty_s;
    logic                    push_s;
    logic                    pop_s;

    assign count = count_r;

    // Dequeue side: bypass the incoming response when empty, else show the head
    always_comb begin
        empty_s  = (count_r == 2'd0);
        deq_val  = 1'b0;
        deq_type = REQ_READ;
        deq_data = {p_data_nbits{1'b0}};
        if (empty_s) begin
            deq_val  = enq_val;
            deq_type = enq_type;
            deq_data = enq_data;
        end else begin
            deq_val  = 1'b1;
            deq_type = head_type_r;
            deq_data = head_data_r;
        end
        // A bypassed response that is consumed immediately is never stored
        push_s = enq_val && !(empty_s && deq_rdy);
        pop_s  = !empty_s && deq_rdy;
    end

    // Storage update: head is always the oldest entry, tail the second
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count_r     <= 2'd0;
            head_type_r <= REQ_READ;
            head_data_r <= {p_data_nbits{1'b0}};
            tail_type_r <= REQ_READ;
            tail_data_r <= {p_data_nbits{1'b0}};
        end else begin
            case ({push_s, pop_s})
                2'b10: begin
                    if (count_r == 2'd0) begin
                        head_type_r <= enq_type;
                        head_data_r <= enq_data;
                        count_r     <= 2'd1;
                    end else if (count_r == 2'd1) begin
                        tail_type_r <= enq_type;
                        tail_data_r <= enq_data;
                        count_r     <= 2'd2;
                    end else begin
                        count_r     <= count_r;
                    end
                end
                2'b01: begin
                    head_type_r <= tail_type_r;
                    head_data_r <= tail_data_r;
                    count_r     <= count_r - 2'd1;
                end
                2'b11: begin
                    if (count_r == 2'd1) begin
                        head_type_r <= enq_type;
                        head_data_r <= enq_data;
                    end else begin
                        head_type_r <= tail_type_r;
                        head_data_r <= tail_data_r;
                        tail_type_r <= enq_type;
                        tail_data_r <= enq_data;
                    end
                end
                default: begin
                    count_r <= count_r;
                end
            endcase
        end
    end

endmodule

// File: rtl/sram_req_arbiter.sv
// ---------------------------------------------------------------------------
// sram_req_arbiter
// Round-robin sharing of one single-port SRAM (1-cycle read latency) between
// two val/rdy requesters. At most one access is issued per cycle; responses
// return to the originating port in order through a per-port 2-entry bypass
// queue, so a stalled consumer on one port never blocks the other.
// Ports:
//   clk, reset                 clock, asynchronous active-high reset
//   p0_req_* / p1_req_*        request channels (val/rdy, type, addr, data, wmask)
//   p0_resp_* / p1_resp_*      response channels (val/rdy, type, data)
//   sram_csb/web/wmask/addr/din  macro controls (active-low select/write)
//   sram_dout                  macro read data, valid the cycle after a read
// ---------------------------------------------------------------------------
module sram_req_arbiter
    import sram_ArbPkg::*;
#(
    parameter  int p_data_nbits  = 32,
    parameter  int p_num_entries = 256,
    localparam int c_addr_nbits  = $clog2(p_num_entries),
    localparam int c_mask_nbits  = p_data_nbits / 8
) (
    input  logic                    clk,
    input  logic                    reset,

    input  logic                    p0_req_val,
    output logic                    p0_req_rdy,
    input  logic                    p0_req_type,
    input  logic [c_addr_nbits-1:0] p0_req_addr,
    input  logic [p_data_nbits-1:0] p0_req_data,
    input  logic [c_mask_nbits-1:0] p0_req_wmask,
    output logic                    p0_resp_val,
    input  logic                    p0_resp_rdy,
    output logic                    p0_resp_type,
    output logic [p_data_nbits-1:0] p0_resp_data,

    input  logic                    p1_req_val,
    output logic                    p1_req_rdy,
    input  logic                    p1_req_type,
    input  logic [c_addr_nbits-1:0] p1_req_addr,
    input  logic [p_data_nbits-1:0] p1_req_data,
    input  logic [c_mask_nbits-1:0] p1_req_wmask,
    output logic                    p1_resp_val,
    input  logic                    p1_resp_rdy,
    output logic                    p1_resp_type,
    output logic [p_data_nbits-1:0] p1_resp_data,

    output logic                    sram_csb,
    output logic                    sram_web,
    output logic [c_mask_nbits-1:0] sram_wmask,
    output logic [c_addr_nbits-1:0] sram_addr,
    output logic [p_data_nbits-1:0] sram_din,
    input  logic [p_data_nbits-1:0] sram_dout
);

    port_id_t                prio_r;
    logic                    infl_val_r;
    port_id_t                infl_port_r;
    logic                    infl_type_r;

    logic [1:0]              q0_count_s;
    logic [1:0]              q1_count_s;
    logic                    infl0_s;
    logic                    infl1_s;
    logic [1:0]              cnt0_s;
    logic [1:0]              cnt1_s;
    logic                    elig0_s;
    logic                    elig1_s;
    logic                    grant_val_s;
    port_id_t                grant_port_s;
    logic                    sel_type_s;
    logic [c_addr_nbits-1:0] sel_addr_s;
    logic [p_data_nbits-1:0] sel_data_s;
    logic [c_mask_nbits-1:0] sel_wmask_s;
    logic [p_data_nbits-1:0] resp_data_s;

    // Credit per port: queued responses plus the one in flight, if it is ours.
    // Based only on registered state, so a dequeue frees credit next cycle.
    always_comb begin
        infl0_s = infl_val_r && (infl_port_r == PORT0);
        infl1_s = infl_val_r && (infl_port_r == PORT1);
        cnt0_s  = q0_count_s + {1'b0, infl0_s};
        cnt1_s  = q1_count_s + {1'b0, infl1_s};
        elig0_s = p0_req_val && (cnt0_s < RESP_Q_DEPTH) && !reset;
        elig1_s = p1_req_val && (cnt1_s < RESP_Q_DEPTH) && !reset;
    end

    // Round-robin grant: prio breaks ties, a lone eligible port always wins
    always_comb begin
        grant_val_s  = 1'b0;
        grant_port_s = PORT0;
        if (elig0_s && elig1_s) begin
            grant_val_s  = 1'b1;
            grant_port_s = prio_r;
        end else if (elig0_s) begin
            grant_val_s  = 1'b1;
            grant_port_s = PORT0;
        end else if (elig1_s) begin
            grant_val_s  = 1'b1;
            grant_port_s = PORT1;
        end else begin
            grant_val_s  = 1'b0;
            grant_port_s = PORT0;
        end
    end

    // Request mux and SRAM drive; idle macro pins sit at their inactive values
    always_comb begin
        if (grant_port_s == PORT1) begin
            sel_type_s  = p1_req_type;
            sel_addr_s  = p1_req_addr;
            sel_data_s  = p1_req_data;
            sel_wmask_s = p1_req_wmask;
        end else begin
            sel_type_s  = p0_req_type;
            sel_addr_s  = p0_req_addr;
            sel_data_s  = p0_req_data;
            sel_wmask_s = p0_req_wmask;
        end

        p0_req_rdy = grant_val_s && (grant_port_s == PORT0);
        p1_req_rdy = grant_val_s && (grant_port_s == PORT1);

        if (grant_val_s) begin
            sram_csb   = 1'b0;
            sram_web   = ~sel_type_s;
            sram_wmask = (sel_type_s == REQ_WRITE) ? sel_wmask_s : {c_mask_nbits{1'b0}};
            sram_addr  = sel_addr_s;
            sram_din   = sel_data_s;
        end else begin
            sram_csb   = 1'b1;
            sram_web   = 1'b1;
            sram_wmask = {c_mask_nbits{1'b0}};
            sram_addr  = {c_addr_nbits{1'b0}};
            sram_din   = {p_data_nbits{1'b0}};
        end
    end

    // In-flight access tracking and priority rotation
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            prio_r      <= PORT0;
            infl_val_r  <= 1'b0;
            infl_port_r <= PORT0;
            infl_type_r <= REQ_READ;
        end else begin
            infl_val_r  <= grant_val_s;
            infl_port_r <= grant_port_s;
            infl_type_r <= sel_type_s;
            if (grant_val_s) begin
                prio_r <= ~grant_port_s;
            end else begin
                prio_r <= prio_r;
            end
        end
    end

    // Response payload: macro data for reads, zero for writes or when idle
    always_comb begin
        if (infl_val_r && (infl_type_r == REQ_READ)) begin
            resp_data_s = sram_dout;
        end else begin
            resp_data_s = {p_data_nbits{1'b0}};
        end
    end

    sram_RespQueue #(.p_data_nbits(p_data_nbits)) u_q0 (
        .clk      (clk),
        .reset    (reset),
        .enq_val  (infl0_s),
        .enq_type (infl_type_r),
        .enq_data (resp_data_s),
        .deq_val  (p0_resp_val),
        .deq_rdy  (p0_resp_rdy),
        .deq_type (p0_resp_type),
        .deq_data (p0_resp_data),
        .count    (q0_count_s)
    );

    sram_RespQueue #(.p_data_nbits(p_data_nbits)) u_q1 (
        .clk      (clk),
        .reset    (reset),
        .enq_val  (infl1_s),
        .enq_type (infl_type_r),
        .enq_data (resp_data_s),
        .deq_val  (p1_resp_val),
        .deq_rdy  (p1_resp_rdy),
        .deq_type (p1_resp_type),
        .deq_data (p1_resp_data),
        .count    (q1_count_s)
    );

endmodule

// File: tb/tb_sram_req_arbiter.sv
// ---------------------------------------------------------------------------
// tb_sram_req_arbiter
// Directed self-checking bench for sram_req_arbiter with a behavioural
// 256x32 byte-maskable SRAM (one-cycle read latency). Memory is preloaded
// with 32'h5A5A0000 + address so read data is predictable.
// ---------------------------------------------------------------------------
module tb_sram_req_arbiter;

    localparam logic [31:0] BASE = 32'h5A5A_0000;

    logic        clk;
    logic        reset;
    logic        p0_req_val, p0_req_rdy, p0_req_type;
    logic [7:0]  p0_req_addr;
    logic [31:0] p0_req_data;
    logic [3:0]  p0_req_wmask;
    logic        p0_resp_val, p0_resp_rdy, p0_resp_type;
    logic [31:0] p0_resp_data;
    logic        p1_req_val, p1_req_rdy, p1_req_type;
    logic [7:0]  p1_req_addr;
    logic [31:0] p1_req_data;
    logic [3:0]  p1_req_wmask;
    logic        p1_resp_val, p1_resp_rdy, p1_resp_type;
    logic [31:0] p1_resp_data;
    logic        sram_csb, sram_web;
    logic [3:0]  sram_wmask;
    logic [7:0]  sram_addr;
    logic [31:0] sram_din;
    logic [31:0] sram_dout;

    logic [31:0] mem [0:255];

    int n_cmp  = 0;
    int n_fail = 0;

    sram_req_arbiter dut (
        .clk          (clk),
        .reset        (reset),
        .p0_req_val   (p0_req_val),
        .p0_req_rdy   (p0_req_rdy),
        .p0_req_type  (p0_req_type),
        .p0_req_addr  (p0_req_addr),
        .p0_req_data  (p0_req_data),
        .p0_req_wmask (p0_req_wmask),
        .p0_resp_val  (p0_resp_val),
        .p0_resp_rdy  (p0_resp_rdy),
        .p0_resp_type (p0_resp_type),
        .p0_resp_data (p0_resp_data),
        .p1_req_val   (p1_req_val),
        .p1_req_rdy   (p1_req_rdy),
        .p1_req_type  (p1_req_type),
        .p1_req_addr  (p1_req_addr),
        .p1_req_data  (p1_req_data),
        .p1_req_wmask (p1_req_wmask),
        .p1_resp_val  (p1_resp_val),
        .p1_resp_rdy  (p1_resp_rdy),
        .p1_resp_type (p1_resp_type),
        .p1_resp_data (p1_resp_data),
        .sram_csb     (sram_csb),
        .sram_web     (sram_web),
        .sram_wmask   (sram_wmask),
        .sram_addr    (sram_addr),
        .sram_din     (sram_din),
        .sram_dout    (sram_dout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural SRAM: masked write, registered read
    always @(posedge clk) begin
        if (!sram_csb) begin
            if (!sram_web) begin
                for (int b = 0; b < 4; b++) begin
                    if (sram_wmask[b]) mem[sram_addr][8*b +: 8] <= sram_din[8*b +: 8];
                end
            end else begin
                sram_dout <= mem[sram_addr];
            end
        end
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic drive_p0(input logic v, input logic t, input logic [7:0] a,
                            input logic [31:0] d, input logic [3:0] m);
        p0_req_val = v; p0_req_type = t; p0_req_addr = a; p0_req_data = d; p0_req_wmask = m;
    endtask

    task automatic drive_p1(input logic v, input logic t, input logic [7:0] a,
                            input logic [31:0] d, input logic [3:0] m);
        p1_req_val = v; p1_req_type = t; p1_req_addr = a; p1_req_data = d; p1_req_wmask = m;
    endtask

    task automatic reset_pulse();
        @(negedge clk);
        reset = 1'b1;
        drive_p0(1'b0, 1'b0, 8'd0, 32'd0, 4'd0);
        drive_p1(1'b0, 1'b0, 8'd0, 32'd0, 4'd0);
        @(negedge clk);
        reset = 1'b0;
    endtask

    initial begin : main
        int a0;
        int a1;
        logic exp_g0;
        logic [5:0] bp_g0;

        for (int i = 0; i < 256; i++) mem[i] = BASE + i;
        reset = 1'b1;
        p0_resp_rdy = 1'b1;
        p1_resp_rdy = 1'b1;
        // Requests held valid during reset must not be granted
        drive_p0(1'b1, 1'b1, 8'd7, 32'h1234_5678, 4'hF);
        drive_p1(1'b1, 1'b1, 8'd9, 32'h8765_4321, 4'hF);

        // ---------------- reset state ----------------
        @(negedge clk); #1;
        check("rst_p0_req_rdy", p0_req_rdy, 0);
        check("rst_p1_req_rdy", p1_req_rdy, 0);
        check("rst_csb", sram_csb, 1);
        check("rst_web", sram_web, 1);
        check("rst_wmask", sram_wmask, 0);
        check("rst_addr", sram_addr, 0);
        check("rst_din", sram_din, 0);
        check("rst_p0_resp_val", p0_resp_val, 0);
        check("rst_p1_resp_val", p1_resp_val, 0);
        check("rst_p0_resp_data", p0_resp_data, 0);
        check("rst_p1_resp_data", p1_resp_data, 0);
        @(negedge clk);
        reset = 1'b0;
        drive_p0(1'b0, 1'b0, 8'd0, 32'd0, 4'd0);
        drive_p1(1'b0, 1'b0, 8'd0, 32'd0, 4'd0);

        // ---------------- write then read ----------------
        @(negedge clk);
        drive_p0(1'b1, 1'b1, 8'd5, 32'hDEAD_BEEF, 4'hF);
        #1;
        check("wr_rdy", p0_req_rdy, 1);
        check("wr_csb", sram_csb, 0);
        check("wr_web", sram_web, 0);
        check("wr_wmask", sram_wmask, 4'hF);
        check("wr_addr", sram_addr, 5);
        check("wr_din", sram_din, 32'hDEAD_BEEF);
        check("wr_no_resp_yet", p0_resp_val, 0);
        @(negedge clk);
        drive_p0(1'b1, 1'b0, 8'd5, 32'd0, 4'hF);
        #1;
        check("rd_rdy", p0_req_rdy, 1);
        check("rd_web", sram_web, 1);
        check("rd_wmask_zero", sram_wmask, 0);
        check("wr_resp_val", p0_resp_val, 1);
        check("wr_resp_type", p0_resp_type, 1);
        check("wr_resp_data", p0_resp_data, 0);
        @(negedge clk);
        drive_p0(1'b0, 1'b0, 8'd0, 32'd0, 4'd0);
        #1;
        check("rd_resp_val", p0_resp_val, 1);
        check("rd_resp_type", p0_resp_type, 0);
        check("rd_resp_data", p0_resp_data, 32'hDEAD_BEEF);
        check("rd_idle_csb", sram_csb, 1);

        // ---------------- byte mask ----------------
        @(negedge clk); drive_p0(1'b1, 1'b1, 8'd3, 32'hFFFF_FFFF, 4'hF);
        @(negedge clk); drive_p0(1'b1, 1'b1, 8'd3, 32'h0000_0000, 4'h5);
        #1; check("mask_wmask", sram_wmask, 4'h5);
        @(negedge clk); drive_p0(1'b1, 1'b0, 8'd3, 32'd0, 4'd0);
        @(negedge clk); drive_p0(1'b0, 1'b0, 8'd0, 32'd0, 4'd0);
        #1;
        check("mask_resp_val", p0_resp_val, 1);
        check("mask_resp_type", p0_resp_type, 0);
        check("mask_resp_data", p0_resp_data, 32'hFF00_FF00);

        // ---------------- contention ----------------
        reset_pulse();
        a0 = 0; a1 = 0;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            drive_p0(1'b1, 1'b0, 8'(10 + a0), 32'd0, 4'd0);
            drive_p1(1'b1, 1'b0, 8'(20 + a1), 32'd0, 4'd0);
            #1;
            exp_g0 = ((k % 2) == 0);
            check("cont_p0_rdy", p0_req_rdy, exp_g0);
            check("cont_p1_rdy", p1_req_rdy, !exp_g0);
            check("cont_csb", sram_csb, 0);
            if (k > 0) begin
                if (((k - 1) % 2) == 0) begin
                    check("cont_p0_resp_val", p0_resp_val, 1);
                    check("cont_p0_resp_data", p0_resp_data, BASE + 10 + (k - 1) / 2);
                    check("cont_p1_resp_idle", p1_resp_val, 0);
                end else begin
                    check("cont_p1_resp_val", p1_resp_val, 1);
                    check("cont_p1_resp_data", p1_resp_data, BASE + 20 + (k - 1) / 2);
                    check("cont_p0_resp_idle", p0_resp_val, 0);
                end
            end
            if (exp_g0) a0++; else a1++;
        end
        @(negedge clk);
        drive_p0(1'b0, 1'b0, 8'd0, 32'd0, 4'd0);
        drive_p1(1'b0, 1'b0, 8'd0, 32'd0, 4'd0);
        #1;
        check("cont_last_p1_val", p1_resp_val, 1);
        check("cont_last_p1_data", p1_resp_data, BASE + 22);

        // ---------------- backpressure isolation ----------------
        reset_pulse();
        p0_resp_rdy = 1'b0;
        bp_g0 = 6'b000101;
        a0 = 0; a1 = 0;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            drive_p0(1'b1, 1'b0, 8'(30 + a0), 32'd0, 4'd0);
            drive_p1(1'b1, 1'b0, 8'(40 + a1), 32'd0, 4'd0);
            #1;
            check("bp_p0_rdy", p0_req_rdy, bp_g0[k]);
            check("bp_p1_rdy", p1_req_rdy, !bp_g0[k]);
            if (k == 2) begin
                check("bp_p1_resp_val", p1_resp_val, 1);
                check("bp_p1_resp_data", p1_resp_data, BASE + 40);
            end
            if (k == 5) begin
                check("bp_p0_stall_val", p0_resp_val, 1);
                check("bp_p0_stall_head", p0_resp_data, BASE + 30);
            end
            if (bp_g0[k]) a0++; else a1++;
        end
        @(negedge clk);
        p0_resp_rdy = 1'b1;
        drive_p1(1'b0, 1'b0, 8'd0, 32'd0, 4'd0);
        #1;
        check("bp_full_p0_rdy", p0_req_rdy, 0);
        check("bp_full_csb", sram_csb, 1);
        check("bp_drain1_val", p0_resp_val, 1);
        check("bp_drain1_data", p0_resp_data, BASE + 30);
        check("bp_p1_last_data", p1_resp_data, BASE + 43);
        @(negedge clk); #1;
        check("bp_resume_rdy", p0_req_rdy, 1);
        check("bp_resume_addr", sram_addr, 32);
        check("bp_drain2_data", p0_resp_data, BASE + 31);
        @(negedge clk);
        drive_p0(1'b0, 1'b0, 8'd0, 32'd0, 4'd0);
        #1;
        check("bp_new_resp_val", p0_resp_val, 1);
        check("bp_new_resp_data", p0_resp_data, BASE + 32);

        // ---------------- reset mid-flight ----------------
        reset_pulse();
        @(negedge clk);
        drive_p1(1'b1, 1'b0, 8'd50, 32'd0, 4'd0);
        #1;
        check("mid_p1_grant", p1_req_rdy, 1);
        @(negedge clk);
        reset = 1'b1;
        drive_p1(1'b0, 1'b0, 8'd0, 32'd0, 4'd0);
        #1;
        check("mid_p1_resp_in_rst", p1_resp_val, 0);
        check("mid_csb_in_rst", sram_csb, 1);
        @(negedge clk);
        reset = 1'b0;
        #1;
        check("mid_p1_resp_after", p1_resp_val, 0);
        @(negedge clk);
        drive_p0(1'b1, 1'b0, 8'd60, 32'd0, 4'd0);
        drive_p1(1'b1, 1'b0, 8'd61, 32'd0, 4'd0);
        #1;
        check("mid_prio_p0", p0_req_rdy, 1);
        check("mid_prio_p1", p1_req_rdy, 0);
        @(negedge clk);
        drive_p0(1'b0, 1'b0, 8'd0, 32'd0, 4'd0);
        drive_p1(1'b0, 1'b0, 8'd0, 32'd0, 4'd0);
        #1;
        check("mid_p0_resp_data", p0_resp_data, BASE + 60);
        check("mid_p1_no_resp", p1_resp_val, 0);

        // ---------------- idle ----------------
        for (int k = 0; k < 10; k++) begin
            @(negedge clk); #1;
            check("idle_csb", sram_csb, 1);
            check("idle_web", sram_web, 1);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
